// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Micro-code sequencer feeding the micro-code side of the fetch-stage
//   pipeline multiplexer. On start it walks a micro-code ROM one group of
//   four micro-ops at a time. Each group is presented on mc_en/mc_ins until
//   the pipeline accepts it. Fetch is stalled via busy for the whole
//   sequence. A flush aborts the sequence. A group-count watchdog aborts a
//   sequence that never delivers its final group.
//
// Ports
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   en          pipeline advance; group consumed when mc_en && en
//   flush       abort sequence (highest priority)
//   start       begin sequence, sampled only in IDLE
//   start_addr  micro-code entry address
//   rom_rd      ROM read strobe (registered)
//   rom_addr    ROM read address (registered, wraps)
//   rom_data    ROM group, valid the cycle after rom_rd
//   rom_cnt     valid slots in group (0..4, 5..7 treated as 4)
//   rom_last    group is the final group of the sequence
//   mc_en       mc_ins valid (registered)
//   mc_ins      micro-op group (registered)
//   busy        sequence active
//   done        one-cycle pulse after the last group is consumed
//   err         one-cycle pulse on watchdog abort
module mc_sequencer #(
    parameter int unsigned     MC_ADDR_W  = 8,
    parameter int unsigned     MAX_GROUPS = 16,
    parameter int unsigned     INSN_W     = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = 'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       start,
    input  logic [MC_ADDR_W-1:0]       start_addr,
    output logic                       rom_rd,
    output logic [MC_ADDR_W-1:0]       rom_addr,
    input  logic [3:0][INSN_W-1:0]     rom_data,
    input  logic [2:0]                 rom_cnt,
    input  logic                       rom_last,
    output logic                       mc_en,
    output logic [3:0][INSN_W-1:0]     mc_ins,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned GRP_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [GRP_W-1:0]         grp_cnt;
    logic                     last_grp;
    logic [2:0]               valid_slots;
    logic [3:0][INSN_W-1:0]   rom_masked;
    logic [3:0][INSN_W-1:0]   nop_group;
    logic                     watchdog_hit;

    assign watchdog_hit = (grp_cnt == GRP_W'(MAX_GROUPS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state_nxt = S_REQ;
                S_REQ:   state_nxt = S_WAIT;
                S_WAIT:  state_nxt = S_ISSUE;
                S_ISSUE: begin
                    if (en) begin
                        if (last_grp || watchdog_hit) state_nxt = S_IDLE;
                        else                          state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Slot masking: slots at or beyond min(rom_cnt,4) become NOPs
    always_comb begin
        valid_slots = (rom_cnt > 3'd4) ? 3'd4 : rom_cnt;
        rom_masked  = '0;
        nop_group   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            nop_group[k]  = NOP_INSN;
            rom_masked[k] = (3'(k) < valid_slots) ? rom_data[k] : NOP_INSN;
        end
    end

    // Registered datapath. rom_rd is raised on the edge entering REQ so it
    // is high for exactly the REQ cycle; the ROM answers during WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            mc_en    <= 1'b0;
            mc_ins   <= {4{NOP_INSN}};
            done     <= 1'b0;
            err      <= 1'b0;
            grp_cnt  <= '0;
            last_grp <= 1'b0;
        end else begin
            rom_rd <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (flush) begin
                mc_en  <= 1'b0;
                mc_ins <= nop_group;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            rom_addr <= start_addr;
                            grp_cnt  <= '0;
                            rom_rd   <= 1'b1;
                        end
                    end
                    S_REQ: begin
                    end
                    S_WAIT: begin
                        mc_ins   <= rom_masked;
                        last_grp <= rom_last;
                        grp_cnt  <= grp_cnt + GRP_W'(1);
                        mc_en    <= 1'b1;
                    end
                    S_ISSUE: begin
                        if (en) begin
                            mc_en  <= 1'b0;
                            mc_ins <= nop_group;
                            if (last_grp) begin
                                done <= 1'b1;
                            end else if (watchdog_hit) begin
                                err <= 1'b1;
                            end else begin
                                rom_addr <= rom_addr + MC_ADDR_W'(1);
                                rom_rd   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
